// File: rtl/fir_folded_pkg.sv
// Shared definitions for the folded FIR: FSM state encoding and a constant clog2.
package fir_folded_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample store with a wrapping write pointer and one offset-addressed read port.
module fir_delay_line
  import fir_folded_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned TAPS  = 16,
  localparam int unsigned AW   = clog2(TAPS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             adv_i,
  input  logic [AW-1:0]    rd_offset_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [TAPS];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      rd_sum;
  logic [AW-1:0]    rd_idx;

  // (wr_ptr - offset) mod TAPS, valid for non-power-of-two TAPS as well
  always_comb begin
    rd_sum = {1'b0, wr_ptr_q} - {1'b0, rd_offset_i};
    if (rd_offset_i > wr_ptr_q) begin
      rd_sum = rd_sum + (AW + 1)'(TAPS);
    end
    rd_idx = rd_sum[AW-1:0];
  end

  assign rd_data_o = mem_q[rd_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
      if (adv_i) begin
        wr_ptr_q <= (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_folded.sv
// Time-multiplexed FIR: one multiplier, one accumulator, TAPS MAC cycles per sample.
module fir_folded
  import fir_folded_pkg::*;
#(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned COEFF_WIDTH = 17,
  parameter int unsigned TAPS        = 16,
  parameter int unsigned SHIFT       = 15
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic signed [WIDTH-1:0]       in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [WIDTH-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          coeff_we,
  input  logic [clog2(TAPS)-1:0]        coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data,
  output logic                          coeff_err
);

  localparam int unsigned AW   = clog2(TAPS);
  localparam int unsigned PW   = WIDTH + COEFF_WIDTH;
  localparam int unsigned AccW = PW + AW;

  state_e                        state_q;
  logic [AW-1:0]                 k_q;
  logic signed [AccW-1:0]        acc_q;
  logic signed [COEFF_WIDTH-1:0] coeff_q [TAPS];
  logic signed [WIDTH-1:0]       out_data_q;
  logic                          out_valid_q;
  logic                          coeff_err_q;

  logic [WIDTH-1:0]       rd_data;
  logic signed [PW-1:0]   prod;
  logic signed [AccW-1:0] acc_d;
  logic signed [AccW-1:0] shifted;
  logic signed [WIDTH-1:0] sat;
  logic                   accept;
  logic                   addr_ok;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;
  assign addr_ok  = ({1'b0, coeff_addr} < (AW + 1)'(TAPS));

  fir_delay_line #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_delay_line (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .wr_en_i     (accept),
    .wr_data_i   (in_data),
    .adv_i       (state_q == StOut),
    .rd_offset_i (k_q),
    .rd_data_o   (rd_data)
  );

  always_comb begin
    prod    = coeff_q[k_q] * $signed(rd_data);
    acc_d   = acc_q + AccW'(prod);
    shifted = acc_q >>> SHIFT;
    sat     = shifted[WIDTH-1:0];
    // Out of range whenever the bits above the output sign bit are not all copies of it
    if (shifted[AccW-1:WIDTH-1] != {(AccW - WIDTH + 1){shifted[AccW-1]}}) begin
      sat = shifted[AccW-1] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      coeff_err_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coeff_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      coeff_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Coefficient lands on the accept edge, so the first MAC already sees it
          if (coeff_we && addr_ok) begin
            coeff_q[coeff_addr] <= coeff_data;
          end
          if (in_valid) begin
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q       <= acc_d;
          k_q         <= k_q + 1'b1;
          coeff_err_q <= coeff_we;
          if (k_q == AW'(TAPS - 1)) begin
            state_q <= StOut;
          end
        end
        StOut: begin
          out_data_q  <= sat;
          out_valid_q <= 1'b1;
          coeff_err_q <= coeff_we;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign coeff_err = coeff_err_q;

endmodule

// File: tb/tb_fir_folded.sv
// Directed bench for fir_folded at TAPS=4, SHIFT=0, WIDTH=10.
module tb_fir_folded;

  logic              clock;
  logic              reset_n;
  logic signed [9:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [9:0] out_data;
  logic              out_valid;
  logic              coeff_we;
  logic [1:0]        coeff_addr;
  logic signed [16:0] coeff_data;
  logic              coeff_err;

  int total = 0;
  int bad   = 0;

  fir_folded #(
    .WIDTH       (10),
    .COEFF_WIDTH (17),
    .TAPS        (4),
    .SHIFT       (0)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .coeff_err  (coeff_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit set_c;
    int c0, c1, c2, c3;
    int sample;
    int expd;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic write_coeff(input int addr, input int data);
    @(negedge clock);
    coeff_we   = 1'b1;
    coeff_addr = 2'(addr);
    coeff_data = 17'(data);
    @(posedge clock);
    #1 coeff_we = 1'b0;
    @(negedge clock);
    check($sformatf("idle_write_err_a%0d", addr), int'(coeff_err), 0);
  endtask

  // Waits (bounded) for out_valid; lat counts negedges since the accept cycle.
  task automatic wait_out(input string name, input int start, input int exp_lat, input int exp_v);
    int lat;
    bit got;
    got = 1'b0;
    lat = start;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if (out_valid) got = 1'b1;
    end
    check({name, "_seen"}, int'(got), 1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_data"}, int'(out_data), exp_v);
    @(negedge clock);
    check({name, "_pulse_end"}, int'(out_valid), 0);
  endtask

  task automatic send(input string name, input int s, input int exp_v);
    @(negedge clock);
    check({name, "_ready"}, int'(in_ready), 1);
    in_data  = 10'(s);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    wait_out(name, 0, 6, exp_v);
  endtask

  initial begin
    int acc_c [3];
    int n;
    int lows;
    int seen;

    vecs[0]  = '{1'b1, 1, 2, 3, 4, 1, 1};
    vecs[1]  = '{1'b0, 0, 0, 0, 0, 0, 2};
    vecs[2]  = '{1'b0, 0, 0, 0, 0, 0, 3};
    vecs[3]  = '{1'b0, 0, 0, 0, 0, 0, 4};
    vecs[4]  = '{1'b0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1'b1, 4, 4, 4, 4, 511, 511};
    vecs[6]  = '{1'b0, 0, 0, 0, 0, 511, 511};
    vecs[7]  = '{1'b0, 0, 0, 0, 0, 511, 511};
    vecs[8]  = '{1'b0, 0, 0, 0, 0, 511, 511};
    vecs[9]  = '{1'b0, 0, 0, 0, 0, -512, 511};
    vecs[10] = '{1'b0, 0, 0, 0, 0, -512, -8};
    vecs[11] = '{1'b0, 0, 0, 0, 0, -512, -512};
    vecs[12] = '{1'b0, 0, 0, 0, 0, -512, -512};
    vecs[13] = '{1'b0, 0, 0, 0, 0, 0, -512};
    vecs[14] = '{1'b0, 0, 0, 0, 0, 0, -512};
    vecs[15] = '{1'b0, 0, 0, 0, 0, 0, -512};
    vecs[16] = '{1'b0, 0, 0, 0, 0, 0, 0};

    reset_n    = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    coeff_we   = 1'b0;
    coeff_addr = '0;
    coeff_data = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_coeff_err", int'(coeff_err), 0);
    reset_n = 1'b1;

    // Impulse, saturation and flush vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].set_c) begin
        write_coeff(0, vecs[i].c0);
        write_coeff(1, vecs[i].c1);
        write_coeff(2, vecs[i].c2);
        write_coeff(3, vecs[i].c3);
      end
      send($sformatf("vec%0d", i), vecs[i].sample, vecs[i].expd);
    end

    // Write during MAC is dropped and flagged one cycle later
    for (int a = 0; a < 4; a++) write_coeff(a, a + 1);
    @(negedge clock);
    in_data  = 10'sd1;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    coeff_we   = 1'b1;
    coeff_addr = 2'd0;
    coeff_data = 17'sd99;
    @(negedge clock);
    coeff_we = 1'b0;
    check("busy_err_pulse", int'(coeff_err), 1);
    @(negedge clock);
    check("busy_err_clear", int'(coeff_err), 0);
    wait_out("busy_imp0", 3, 6, 1);
    send("busy_imp1", 0, 2);
    send("busy_imp2", 0, 3);
    send("busy_imp3", 0, 4);
    send("busy_imp4", 0, 0);

    // Coefficient write on the accept edge applies to that sample
    @(negedge clock);
    in_data    = 10'sd1;
    in_valid   = 1'b1;
    coeff_we   = 1'b1;
    coeff_addr = 2'd0;
    coeff_data = 17'sd7;
    @(posedge clock);
    #1 in_valid = 1'b0;
    coeff_we = 1'b0;
    @(negedge clock);
    check("simul_err", int'(coeff_err), 0);
    wait_out("simul", 1, 6, 7);

    // Back-to-back with in_valid held high: samples 1,0,0 -> last out 3*1+4*1
    n    = 0;
    lows = 0;
    in_data  = 10'sd1;
    in_valid = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (in_ready) begin
        acc_c[n] = c;
        n++;
        @(posedge clock);
        #1;
        if (n < 3) in_data = 10'sd0;
        else in_valid = 1'b0;
      end else begin
        lows++;
      end
      if (n < 3) @(negedge clock);
    end
    check("b2b_accepts", n, 3);
    check("b2b_gap01", acc_c[1] - acc_c[0], 6);
    check("b2b_gap12", acc_c[2] - acc_c[1], 6);
    check("b2b_ready_low", lows, 10);
    wait_out("b2b_last", 0, 6, 7);

    // Reset in MAC k=2 aborts the sample and clears coefficients
    @(negedge clock);
    in_data  = 10'sd5;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("mid_rst_no_valid", seen, 0);
    send("post_rst_imp", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_folded.md
FIR_FOLDED -- requirements
Module: fir_folded

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning sample width (signed two's complement, in and out).
REQ-002 The block SHALL have parameter COEFF_WIDTH, default 17, meaning coefficient width (signed).
REQ-003 The block SHALL have parameter TAPS, default 16, meaning filter length (range 2..256).
REQ-004 The block SHALL have parameter SHIFT, default 15, meaning arithmetic right shift applied to the accumulator before output.
REQ-005 The block SHALL have one clock, `clock`, and its reset SHALL be asynchronous and active-low, named `reset_n`.
REQ-006 The ports SHALL be, in this order:
- clock  input  1  rising-edge clock
- reset_n  input  1  async active-low reset
- in_data  input  WIDTH  input sample
- in_valid  input  1  sample offered
- in_ready  output  1  block can accept a sample
- out_data  output  WIDTH  filtered sample
- out_valid  output  1  single-cycle pulse marking out_data valid
- coeff_we  input  1  coefficient write strobe
- coeff_addr  input  clog2(TAPS)  tap index (0 = newest sample)
- coeff_data  input  COEFF_WIDTH  coefficient value
- coeff_err  output  1  single-cycle pulse when a write is dropped

Function
REQ-007 The filter SHALL be time-multiplexed: one multiplier and one accumulator, with all tap products summed over TAPS consecutive cycles.
REQ-008 The FSM SHALL have states IDLE, MAC and OUT; in_ready SHALL be 1 only in IDLE.
REQ-009 A sample SHALL be accepted when in_valid and in_ready are both 1 on a clock edge. On that edge:
- the sample is written to the delay line at wr_ptr;
- the accumulator is cleared;
- k is set to 0;
- the FSM moves to MAC.
REQ-010 In MAC, each cycle SHALL perform acc += coeff[k] * sample[(wr_ptr - k) mod TAPS] and then k += 1.
REQ-011 The FSM SHALL leave MAC for OUT after the k = TAPS-1 product.
REQ-012 In OUT, the block SHALL:
- register out_data = saturate(acc >>> SHIFT) to the signed WIDTH range;
- pulse out_valid for exactly one cycle;
- advance wr_ptr by 1, wrapping from TAPS-1 to 0;
- return to IDLE.
REQ-013 The accumulator SHALL be WIDTH + COEFF_WIDTH + clog2(TAPS) bits wide and SHALL never overflow internally.
REQ-014 Latency SHALL be exactly TAPS+2 cycles from the accept edge to the out_valid cycle; maximum throughput SHALL be one sample per TAPS+2 cycles.
REQ-015 out_data SHALL hold its last value until the next OUT state.
REQ-016 A coefficient write SHALL take effect when coeff_we = 1 in IDLE.
REQ-017 A write in IDLE that coincides with a sample accept SHALL be applied before the first MAC cycle, so the new coefficient is used for that sample.
REQ-018 coeff_we = 1 in MAC or OUT SHALL be dropped, leave coefficients unchanged, and pulse coeff_err the next cycle.

Reset
REQ-019 While reset_n = 0, the block SHALL force:
- FSM to IDLE;
- wr_ptr, k and acc to 0;
- all delay-line entries and all coefficients to 0;
- out_data to 0;
- out_valid and coeff_err to 0;
- in_ready to 1 after release.
REQ-020 Reset asserted during MAC or OUT SHALL abort the computation, and no out_valid SHALL follow.

Structure
REQ-021 The shared package SHALL hold the FSM state encodings and a clog2 constant function.
REQ-022 The delay line and its wrapping pointer SHALL be one sub-module, fir_delay_line, with parameters WIDTH and TAPS, a write port, and one combinational read port addressed by offset.

Verification
REQ-023 The bench SHALL cover these directed scenarios (TAPS=4, SHIFT=0 unless stated):
- Impulse: coeffs {1,2,3,4}, samples 1,0,0,0,0 -> out_data 1,2,3,4,0, each exactly 6 cycles after its accept.
- Saturation: WIDTH=10, coeffs all 4, samples 511 x4 -> out_data 511; samples -512 x4 -> out_data -512.
- Back-to-back: in_valid held high with 3 samples -> accepts exactly 6 cycles apart, in_ready low for 5 cycles after each accept.
- Busy write: coeff_we during MAC -> coeff_err pulses 1 cycle and the next impulse response is unchanged.
- Simultaneous: coeff_addr 0 written with 7 on the accept edge of sample 1 -> out_data 7.
- Reset mid-MAC: reset_n low at MAC k=2 -> no out_valid, then the next impulse reproduces all-zero-coefficient output 0.
